flight_mission_sequencer: RTL and testbench

FLIGHT_MISSION_SEQUENCER -- requirements
Module: flight_mission_sequencer

---
 rtl/flight_mission_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_flight_mission_sequencer.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flight_mission_sequencer.sv
// flight_mission_sequencer
//   Mission-level sequencer in front of an autopilot core. Waypoint altitudes
//   are queued in a small FIFO; on start each waypoint is handed to the
//   autopilot with a reset / load handshake and flown until the autopilot
//   reports it reached. Faults park the sequencer until abort.
//
//   Optional build macro: MISSION_TIMEOUT_EN adds a per-waypoint FLY
//   watchdog of TIMEOUT cycles that forces FAULT when it expires.
//
// Parameters
//   DEPTH       waypoint FIFO entries (power of two, 2..8)
//   TIMEOUT     max FLY cycles per waypoint (1..255), used with the macro
// Ports
//   clk, rst              clock, synchronous active-high reset
//   wp_valid/wp_alt       waypoint push request and 6-bit altitude
//   wp_ready              FIFO not full (push accepted on wp_valid&&wp_ready)
//   wp_reject             pulse: accepted push dropped (altitude < 10)
//   start, abort          begin mission / cancel mission and flush FIFO
//   ap_rst, ap_load       autopilot reset and target-valid strobe
//   ap_alt                target altitude, holds last loaded value
//   ap_reached, ap_fault  autopilot status, sampled only in FLY
//   busy, done, fault     mission status (done is a pulse, fault a level)
//   wp_count              waypoints reached this mission (saturates at 7)

module flight_mission_sequencer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wp_valid,
    input  logic [5:0] wp_alt,
    output logic       wp_ready,
    output logic       wp_reject,
    input  logic       start,
    input  logic       abort,
    output logic       ap_rst,
    output logic       ap_load,
    output logic [5:0] ap_alt,
    input  logic       ap_reached,
    input  logic       ap_fault,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [2:0] wp_count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    if (DEPTH < 2 || DEPTH > 8 || (DEPTH & (DEPTH - 1)) != 0 ||
        TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
        $error("flight_mission_sequencer: DEPTH or TIMEOUT out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_LOAD,
        S_FLY,
        S_NEXT,
        S_DONE,
        S_FAULT
    } state_t;

    state_t        state_q, state_d;

    logic [5:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;

    logic          wp_ready_q, wp_reject_q;
    logic          ap_rst_q, ap_load_q;
    logic [5:0]    ap_alt_q;
    logic          busy_q, done_q, fault_q;
    logic [2:0]    wp_count_q;

    logic          push_acc, push_store, pop;

`ifdef MISSION_TIMEOUT_EN
    logic [7:0]    timer_q;
`endif

    always_comb begin
        // wp_ready_q mirrors registered occupancy, so a full FIFO refuses a
        // push even in the cycle it is being popped.
        push_acc   = wp_valid && wp_ready_q && !abort;
        push_store = push_acc && (wp_alt >= 6'd10);
        // The head is popped on the ARM->LOAD edge so that ap_alt and
        // ap_load are both presented during the LOAD cycle.
        pop        = (state_q == S_ARM) && !abort;

        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start && count_q != '0) state_d = S_ARM;
            S_ARM:   state_d = S_LOAD;
            S_LOAD:  state_d = S_FLY;
            S_FLY: begin
                if (ap_fault)        state_d = S_FAULT;
                else if (ap_reached) state_d = S_NEXT;
`ifdef MISSION_TIMEOUT_EN
                // timer_q counts completed FLY cycles; the last allowed
                // cycle is the one where it equals TIMEOUT-1.
                else if (timer_q == 8'(TIMEOUT - 1)) state_d = S_FAULT;
`endif
            end
            S_NEXT:  state_d = (count_q == '0) ? S_DONE : S_ARM;
            S_DONE:  state_d = S_IDLE;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;

        count_d = count_q;
        if (abort) begin
            count_d = '0;
        end else begin
            case ({push_store, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wp_ready_q  <= 1'b0;
            wp_reject_q <= 1'b0;
            ap_rst_q    <= 1'b0;
            ap_load_q   <= 1'b0;
            ap_alt_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            wp_count_q  <= '0;
`ifdef MISSION_TIMEOUT_EN
            timer_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;

            if (abort) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push_store) begin
                    mem_q[wr_ptr_q] <= wp_alt;
                    wr_ptr_q        <= wr_ptr_q + AW'(1);
                end
                if (pop) begin
                    ap_alt_q <= mem_q[rd_ptr_q];
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                end
            end

`ifdef MISSION_TIMEOUT_EN
            if (abort || state_q == S_LOAD) timer_q <= '0;
            else if (state_q == S_FLY)      timer_q <= timer_q + 8'd1;
`endif

            if (state_q == S_IDLE && state_d == S_ARM) begin
                wp_count_q <= '0;
            end else if (state_d == S_NEXT && wp_count_q != 3'd7) begin
                wp_count_q <= wp_count_q + 3'd1;
            end

            // Status outputs are registered from the next state so they line
            // up with the state they describe.
            wp_ready_q  <= (count_d != CW'(DEPTH));
            wp_reject_q <= push_acc && !push_store;
            ap_rst_q    <= abort || (state_d == S_ARM) || (state_d == S_FAULT);
            ap_load_q   <= (state_d == S_LOAD);
            busy_q      <= !(state_d inside {S_IDLE, S_DONE, S_FAULT});
            done_q      <= (state_d == S_DONE);
            fault_q     <= (state_d == S_FAULT);
        end
    end

    assign wp_ready  = wp_ready_q;
    assign wp_reject = wp_reject_q;
    assign ap_rst    = ap_rst_q;
    assign ap_load   = ap_load_q;
    assign ap_alt    = ap_alt_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign fault     = fault_q;
    assign wp_count  = wp_count_q;

endmodule

// File: tb/tb_flight_mission_sequencer.sv
// Testbench for flight_mission_sequencer: scenario tasks with a queue model
// of the waypoint FIFO and a transaction-level view of each mission.

module tb_flight_mission_sequencer;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 200;

    logic       clk = 1'b0;
    logic       rst, wp_valid, start, abort, ap_reached, ap_fault;
    logic [5:0] wp_alt;
    logic       wp_ready, wp_reject, ap_rst, ap_load, busy, done, fault;
    logic [5:0] ap_alt;
    logic [2:0] wp_count;

    int checks = 0;
    int errors = 0;
    int fifo_m[$];
    int pending[$];

    flight_mission_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .wp_valid(wp_valid), .wp_alt(wp_alt), .wp_ready(wp_ready), .wp_reject(wp_reject),
        .start(start), .abort(abort),
        .ap_rst(ap_rst), .ap_load(ap_load), .ap_alt(ap_alt),
        .ap_reached(ap_reached), .ap_fault(ap_fault),
        .busy(busy), .done(done), .fault(fault), .wp_count(wp_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wp(input int alt);
        int   waited = 0;
        logic exp_rej;
        while (wp_ready !== 1'b1 && waited < 50) begin
            step();
            waited++;
        end
        checks++;
        if (wp_ready !== 1'b1) begin
            errors++;
            $display("FAIL push_ready_wait got %b want 1", wp_ready);
        end else begin
            exp_rej  = (alt < 10);
            wp_valid = 1'b1;
            wp_alt   = 6'(alt);
            step();
            wp_valid = 1'b0;
            checks++;
            if (wp_reject !== exp_rej) begin
                errors++;
                $display("FAIL push_reject alt=%0d got %b want %b", alt, wp_reject, exp_rej);
            end
            if (alt >= 10) fifo_m.push_back(alt);
        end
    endtask

    // Runs from the ARM cycle of a mission until it is back in IDLE,
    // acting as the autopilot. Waypoints in 'pending' are pushed during LOAD.
    task automatic fly_mission(input int fixed_d, input int cnt0);
        int cnt = cnt0;
        int exp_alt, d;
        for (int it = 0; it < 20; it++) begin
            checks++;
            if ({ap_rst, ap_load, busy, done} !== 4'b1010 || wp_count !== 3'(cnt)) begin
                errors++;
                $display("FAIL arm rst/load/busy/done=%b%b%b%b cnt=%0d want 1010 cnt=%0d",
                         ap_rst, ap_load, busy, done, wp_count, cnt);
            end
            ap_reached = 1'($urandom_range(0, 1));
            ap_fault   = 1'($urandom_range(0, 1));
            step();
            ap_reached = 1'b0;
            ap_fault   = 1'b0;
            exp_alt = fifo_m.pop_front();
            checks++;
            if (ap_load !== 1'b1 || ap_rst !== 1'b0 || ap_alt !== 6'(exp_alt) || wp_ready !== 1'b1) begin
                errors++;
                $display("FAIL load ap_load=%b ap_rst=%b ap_alt=%0d ready=%b want 1 0 %0d 1",
                         ap_load, ap_rst, ap_alt, wp_ready, exp_alt);
            end
            d = (fixed_d > 0) ? fixed_d : $urandom_range(2, 8);
            for (int k = 0; k < d; k++) begin
                int pv = -1;
                if (k == 0 && pending.size() > 0) begin
                    pv = pending.pop_front();
                    wp_valid = 1'b1;
                    wp_alt   = 6'(pv);
                end
                step();
                wp_valid = 1'b0;
                if (pv >= 0) fifo_m.push_back(pv);
                checks++;
                if (ap_load !== 1'b0 || ap_rst !== 1'b0 || busy !== 1'b1 ||
                    ap_alt !== 6'(exp_alt) || wp_reject !== 1'b0) begin
                    errors++;
                    $display("FAIL fly load=%b rst=%b busy=%b alt=%0d rej=%b want 0 0 1 %0d 0",
                             ap_load, ap_rst, busy, ap_alt, wp_reject, exp_alt);
                end
            end
            ap_reached = 1'b1;
            step();
            ap_reached = 1'b0;
            cnt = (cnt < 7) ? cnt + 1 : 7;
            checks++;
            if (wp_count !== 3'(cnt) || busy !== 1'b1 || ap_load !== 1'b0) begin
                errors++;
                $display("FAIL next wp_count=%0d busy=%b want %0d 1", wp_count, busy, cnt);
            end
            step();
            if (fifo_m.size() == 0) begin
                checks++;
                if ({done, busy, ap_rst} !== 3'b100) begin
                    errors++;
                    $display("FAIL done done/busy/rst=%b%b%b want 100", done, busy, ap_rst);
                end
                step();
                checks++;
                if ({done, busy} !== 2'b00 || wp_count !== 3'(cnt)) begin
                    errors++;
                    $display("FAIL idle_after_done done/busy=%b%b cnt=%0d want 00 %0d",
                             done, busy, wp_count, cnt);
                end
                break;
            end
        end
    endtask

    task automatic run_mission(input int n, input int fixed_d);
        int alts[$];
        for (int i = 0; i < n; i++) alts.push_back($urandom_range(10, 63));
        for (int i = 0; i < n; i++) begin
            if (i < DEPTH) begin
                if ($urandom_range(0, 3) == 0) push_wp($urandom_range(0, 9));
                push_wp(alts[i]);
            end else begin
                pending.push_back(alts[i]);
            end
        end
        start = 1'b1;
        step();
        start = 1'b0;
        fly_mission(fixed_d, 0);
    endtask

    task automatic test_reset();
        rst = 1'b1; wp_valid = 1'b0; wp_alt = '0; start = 1'b0; abort = 1'b0;
        ap_reached = 1'b0; ap_fault = 1'b0;
        repeat (3) step();
        checks++;
        if ({ap_rst, ap_load, wp_reject, done, fault, busy} !== 6'b0 ||
            wp_count !== 3'd0 || ap_alt !== 6'd0) begin
            errors++;
            $display("FAIL reset_outputs ctl=%b%b%b%b%b%b cnt=%0d alt=%0d want all 0",
                     ap_rst, ap_load, wp_reject, done, fault, busy, wp_count, ap_alt);
        end
        rst = 1'b0;
        step();
        checks++;
        if (wp_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready ready=%b busy=%b want 1 0", wp_ready, busy);
        end
    endtask

    task automatic test_reject();
        push_wp(5);
        step();
        checks++;
        if (wp_reject !== 1'b0) begin
            errors++;
            $display("FAIL reject_pulse_width got %b want 0", wp_reject);
        end
        push_wp(9);
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || ap_rst !== 1'b0) begin
            errors++;
            $display("FAIL start_empty busy=%b ap_rst=%b want 0 0", busy, ap_rst);
        end
        step();
        checks++;
        if (busy !== 1'b0 || ap_load !== 1'b0) begin
            errors++;
            $display("FAIL start_empty_2 busy=%b ap_load=%b want 0 0", busy, ap_load);
        end
    endtask

    task automatic test_directed_mission();
        push_wp(20);
        push_wp(30);
        start = 1'b1;
        step();
        start = 1'b0;
        fly_mission(5, 0);
        push_wp(10);
        push_wp(63);
        start = 1'b1;
        step();
        start = 1'b0;
        fly_mission(0, 0);
    endtask

    task automatic test_backpressure();
        int exp_alt;
        for (int i = 0; i < DEPTH; i++) push_wp($urandom_range(10, 63));
        checks++;
        if (wp_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready got %b want 0", wp_ready);
        end
        wp_valid = 1'b1;
        wp_alt   = 6'd40;
        step();
        checks++;
        if (wp_ready !== 1'b0 || wp_reject !== 1'b0) begin
            errors++;
            $display("FAIL full_hold ready=%b rej=%b want 0 0", wp_ready, wp_reject);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (wp_ready !== 1'b0 || ap_rst !== 1'b1) begin
            errors++;
            $display("FAIL full_arm ready=%b ap_rst=%b want 0 1", wp_ready, ap_rst);
        end
        step();
        exp_alt = fifo_m.pop_front();
        checks++;
        if (wp_ready !== 1'b1 || ap_load !== 1'b1 || ap_alt !== 6'(exp_alt)) begin
            errors++;
            $display("FAIL full_load ready=%b load=%b alt=%0d want 1 1 %0d",
                     wp_ready, ap_load, ap_alt, exp_alt);
        end
        step();
        wp_valid = 1'b0;
        fifo_m.push_back(40);
        checks++;
        if (wp_ready !== 1'b0 || wp_reject !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL full_refill ready=%b rej=%b busy=%b want 0 0 1", wp_ready, wp_reject, busy);
        end
        ap_reached = 1'b1;
        step();
        ap_reached = 1'b0;
        checks++;
        if (wp_count !== 3'd1) begin
            errors++;
            $display("FAIL full_next wp_count=%0d want 1", wp_count);
        end
        step();
        fly_mission(0, 1);
    endtask

    task automatic test_fault();
        push_wp($urandom_range(10, 63));
        push_wp($urandom_range(10, 63));
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        void'(fifo_m.pop_front());
        repeat ($urandom_range(1, 4)) step();
        ap_fault = 1'b1;
        ap_reached = 1'b1;
        step();
        ap_fault = 1'b0;
        ap_reached = 1'b0;
        checks++;
        if ({fault, ap_rst, busy, done} !== 4'b1100 || wp_count !== 3'd0) begin
            errors++;
            $display("FAIL fault_enter fault/rst/busy/done=%b%b%b%b cnt=%0d want 1100 0",
                     fault, ap_rst, busy, done, wp_count);
        end
        for (int i = 0; i < 4; i++) begin
            start      = 1'($urandom_range(0, 1));
            ap_reached = 1'($urandom_range(0, 1));
            step();
            checks++;
            if (fault !== 1'b1 || ap_rst !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL fault_hold fault=%b rst=%b busy=%b want 1 1 0", fault, ap_rst, busy);
            end
        end
        start = 1'b0;
        ap_reached = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        fifo_m.delete();
        checks++;
        if ({fault, ap_rst, busy, wp_ready} !== 4'b0101) begin
            errors++;
            $display("FAIL fault_abort fault/rst/busy/ready=%b%b%b%b want 0101",
                     fault, ap_rst, busy, wp_ready);
        end
        step();
        checks++;
        if (ap_rst !== 1'b0) begin
            errors++;
            $display("FAIL fault_abort_pulse ap_rst=%b want 0", ap_rst);
        end
    endtask

    task automatic test_abort();
        for (int i = 0; i < 3; i++) push_wp($urandom_range(10, 63));
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        void'(fifo_m.pop_front());
        repeat (2) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        fifo_m.delete();
        checks++;
        if ({ap_rst, busy, wp_ready, fault, done} !== 5'b10100) begin
            errors++;
            $display("FAIL abort_fly rst/busy/ready/fault/done=%b%b%b%b%b want 10100",
                     ap_rst, busy, wp_ready, fault, done);
        end
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || ap_rst !== 1'b0) begin
            errors++;
            $display("FAIL abort_flushed busy=%b ap_rst=%b want 0 0", busy, ap_rst);
        end
    endtask

    task automatic test_timeout();
        push_wp(33);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        void'(fifo_m.pop_front());
        checks++;
        if (ap_load !== 1'b1) begin
            errors++;
            $display("FAIL timeout_load ap_load=%b want 1", ap_load);
        end
`ifdef MISSION_TIMEOUT_EN
        begin
            int first = -1;
            for (int c = 1; c <= TIMEOUT + 5; c++) begin
                step();
                if (fault === 1'b1 && first < 0) first = c;
            end
            checks++;
            if (first != TIMEOUT + 1 || wp_count !== 3'd0) begin
                errors++;
                $display("FAIL timeout_fault first fault cycle=%0d cnt=%0d want %0d 0",
                         first, wp_count, TIMEOUT + 1);
            end
        end
`else
        begin
            int bad = 0;
            for (int c = 1; c <= 1000; c++) begin
                step();
                if (busy !== 1'b1 || fault !== 1'b0) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL no_timeout cycles left FLY=%0d want 0", bad);
            end
        end
`endif
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        push_wp($urandom_range(10, 63));
        push_wp($urandom_range(10, 63));
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        fifo_m.delete();
        checks++;
        if ({done, fault, busy, ap_rst, ap_load} !== 5'b0 || wp_count !== 3'd0 || ap_alt !== 6'd0) begin
            errors++;
            $display("FAIL reset_mid done/fault/busy/rst/load=%b%b%b%b%b cnt=%0d alt=%0d want 0",
                     done, fault, busy, ap_rst, ap_load, wp_count, ap_alt);
        end
        rst = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (wp_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_after ready=%b busy=%b done=%b fault=%b want 1 0 0 0",
                     wp_ready, busy, done, fault);
        end
    endtask

    initial begin
        test_reset();
        test_reject();
        test_directed_mission();
        test_backpressure();
        test_fault();
        test_abort();
        test_timeout();
        test_reset_mid();
        for (int m = 0; m < 15; m++) run_mission($urandom_range(1, 9), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
